sequencer: RTL and testbench
============================

Name: sequencer

Overview:
- Table-driven output sequencer for the PandA position/bit bus.
- The host loads a table of 4-word lines through register strobes.
- On enable, each line waits for a trigger condition on bita/bitb/bitc. It then drives output pattern phase 1 for a timed interval, then output pattern phase 2 for a timed interval.
- Each line repeats a set number of times, and the whole table repeats REPEATS times.
- Progress counters and state are exported for status readback.

Parameters:
- SEQ_LEN, 1024: table memory depth in 32-bit words (256 lines).

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  run gate; a rising edge starts the table, a falling edge aborts it
- bita_i, bitb_i, bitc_i  in  1 each  trigger inputs
- posa_i, posb_i, posc_i  in  32 each  position inputs; reserved and ignored in this revision
- outa_o..outf_o  out  1 each  sequenced outputs
- active_o  out  1  sequence running
- PRESCALE  in  32  tick divider in clocks; 0 and 1 both mean one tick per clock
- TABLE_START  in  1  pulse: reset the table write pointer and invalidate the table
- TABLE_DATA  in  32  table write data
- TABLE_WSTB  in  1  write TABLE_DATA at the pointer, then increment the pointer
- REPEATS  in  32  table repeat count; 0 = infinite
- TABLE_LENGTH  in  16  table length in words
- TABLE_LENGTH_WSTB  in  1  commit the length; the table becomes valid if the length is nonzero
- table_line_o  out  32  current line, 1-based; 0 when idle
- line_repeat_o  out  32  current line iteration, 1-based
- table_repeat_o  out  32  current table iteration, 1-based
- state_o  out  3  0 UNREADY, 1 WAIT_ENABLE, 2 WAIT_TRIGGER, 3 PHASE1, 4 PHASE2

Behaviour:
- Reset (async):
  - All outputs and counters 0; state UNREADY.
  - Length cleared and write pointer 0. Memory contents need not be cleared.
- Line format (words 4n..4n+3):
  - w0: line repeat count; 0 = infinite.
  - w1: [2:0] condition value (c,b,a); [6:4] condition mask; [13:8] phase-1 outputs (f..a); [21:16] phase-2 outputs (f..a).
  - w2: phase-1 duration in ticks.
  - w3: phase-2 duration in ticks.
  - A duration of 0 is treated as 1.
- Line count = TABLE_LENGTH/4. The low 2 bits of TABLE_LENGTH are ignored.
- Writes beyond SEQ_LEN are discarded.
- TABLE_START at any time: abort to UNREADY, outputs 0, active_o 0.
- TABLE_LENGTH_WSTB: if the line count is nonzero, go to WAIT_ENABLE; otherwise go to UNREADY.
  - If enable_i is already high at commit, the block does not start; it waits for the next rising edge.
- Rising edge of enable_i in WAIT_ENABLE: next clock, active_o=1, line=1, line_repeat=1, table_repeat=1, state WAIT_TRIGGER.
- WAIT_TRIGGER:
  - Trigger is satisfied when ((inputs XOR value) AND mask) = 0; mask 0 triggers immediately.
  - On the edge that samples the trigger true, the outputs load the phase-1 pattern and the state becomes PHASE1. This is one-clock latency from input to output.
- Prescaler restarts at entry to each phase. A phase lasts duration × max(PRESCALE,1) clocks.
- At the end of PHASE1: outputs load phase-2, state PHASE2.
- At the end of PHASE2 (all transitions take effect on the same edge):
  - If line_repeat < w0 or w0 = 0: line_repeat+1, go to WAIT_TRIGGER.
  - Else, if a next line exists: line+1, line_repeat=1.
  - Else, if table_repeat < REPEATS or REPEATS = 0: line=1, table_repeat+1.
  - Else: finish.
- Outputs keep the phase-2 pattern during WAIT_TRIGGER of the next iteration.
- Finish or falling edge of enable_i: outputs 0, active_o 0, counters 0, state WAIT_ENABLE.
- Counters wrap at 2^32 when infinite.
- Simultaneous events:
  - TABLE_START beats enable_i edges.
  - An enable_i falling edge beats a phase end.
  - reset_i beats everything.

Decomposition:
- Package seq_pkg:
  - state encoding constants.
  - w1 bit-field offsets/widths.
  - SEQ_LEN default.
- One natural sub-module: seq_table, the dual-port table RAM with write pointer, length register and read address (line*4+word). Read latency is one clock; line words are prefetched into registers when a line starts.

Test Plan:
- Load 4 words [1, 0x00000100, 5, 3], REPEATS=1, PRESCALE=1, then enable high → outa_o high for 5 clocks, then low for 3 clocks; active_o falls and state returns to 1 (WAIT_ENABLE).
- Same table with PRESCALE=10 → outa_o high for 50 clocks; table_line_o=1, line_repeat_o=1, table_repeat_o=1 throughout.
- Trigger test: w1=0x00020111 (value a=1, mask a, ph1 A, ph2 B), enable with bita_i=0 → state 2 (WAIT_TRIGGER) holds; raise bita_i → one clock later outa_o=1 and state 3 (PHASE1).
- Two lines with repeats 2 and 1, REPEATS=2 → line/line_repeat/table_repeat step (1,1,1),(1,2,1),(2,1,1),(1,1,2),(1,2,2),(2,1,2) and the sequence then finishes.
- Drop enable_i mid-PHASE1 → next clock all outputs 0, active_o 0, state 1 (WAIT_ENABLE).
- TABLE_START mid-run → state 0 (UNREADY) and enable is ignored until a nonzero TABLE_LENGTH_WSTB; assert reset_i mid-run → immediate all-zero outputs and state 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the table-driven output sequencer.
package seq_pkg;

   localparam int SEQ_LEN_DEF = 1024;

   typedef enum logic [2:0] {
      ST_UNREADY      = 3'd0,
      ST_WAIT_ENABLE  = 3'd1,
      ST_WAIT_TRIGGER = 3'd2,
      ST_PHASE1       = 3'd3,
      ST_PHASE2       = 3'd4
   } state_t;

   // Second word of a line: trigger value/mask and the two output patterns.
   localparam int COND_W      = 3;
   localparam int OUT_W       = 6;
   localparam int W1_VAL_LSB  = 0;
   localparam int W1_MASK_LSB = 4;
   localparam int W1_PH1_LSB  = 8;
   localparam int W1_PH2_LSB  = 16;

   // Terminal-count load value: a down-counter loaded with this reaches zero
   // after max(n,1) counts, so 0 and 1 behave identically.
   function automatic logic [31:0] tc_load(input logic [31:0] n);
      return (n == 32'd0) ? 32'd0 : n - 32'd1;
   endfunction

endpackage

// File: rtl/seq_table.sv
// Table RAM with host write pointer, committed line count and a registered
// read port used by the sequencer to prefetch line words.
module seq_table
   import seq_pkg::*;
#(
   parameter  int SEQ_LEN = SEQ_LEN_DEF,
   localparam int ADDR_W  = $clog2(SEQ_LEN)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              table_start_i,
   input  logic [31:0]       table_data_i,
   input  logic              table_wstb_i,
   input  logic [13:0]       table_lines_i,
   input  logic              table_length_wstb_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [31:0]       rd_data_o,
   output logic [13:0]       line_count_o
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(SEQ_LEN);

   logic [31:0]     mem_q [SEQ_LEN];
   logic [31:0]     rd_data_q;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [13:0]     line_count_q, line_count_d;
   logic            wr_en;

   // Pointer saturates at the depth so overflow writes are dropped, not wrapped.
   always_comb begin
      wr_en        = table_wstb_i && !table_start_i && (wr_ptr_q < DEPTH);
      wr_ptr_d     = wr_ptr_q;
      line_count_d = line_count_q;
      if (table_start_i) begin
         wr_ptr_d     = '0;
         line_count_d = '0;
      end else begin
         if (wr_en)
            wr_ptr_d = wr_ptr_q + 1'b1;
         if (table_length_wstb_i)
            line_count_d = table_lines_i;
      end
   end

   // Pointer and length registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q     <= '0;
         line_count_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         line_count_q <= line_count_d;
      end
   end

   // RAM array: no reset so it maps onto block memory.
   always_ff @(posedge clk_i) begin
      if (wr_en)
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= table_data_i;
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o    = rd_data_q;
   assign line_count_o = line_count_q;

endmodule

// File: rtl/sequencer.sv
// Table-driven output sequencer: per line, wait for a trigger, drive phase-1
// then phase-2 patterns for timed intervals, with line and table repeats.
//
//   state           | meaning
//   ----------------+-------------------------------------------------------
//   ST_UNREADY      | no valid table committed
//   ST_WAIT_ENABLE  | table valid, waiting for a rising edge on enable_i
//   ST_WAIT_TRIGGER | line words loading, then waiting for trigger condition
//   ST_PHASE1       | driving phase-1 pattern for its duration
//   ST_PHASE2       | driving phase-2 pattern for its duration
//
// Entering WAIT_TRIGGER on a new line spends five clocks prefetching the
// line's four words before the trigger is evaluated.
module sequencer
   import seq_pkg::*;
#(
   parameter int SEQ_LEN = SEQ_LEN_DEF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        bita_i,
   input  logic        bitb_i,
   input  logic        bitc_i,
   input  logic [31:0] posa_i,
   input  logic [31:0] posb_i,
   input  logic [31:0] posc_i,
   output logic        outa_o,
   output logic        outb_o,
   output logic        outc_o,
   output logic        outd_o,
   output logic        oute_o,
   output logic        outf_o,
   output logic        active_o,
   input  logic [31:0] PRESCALE,
   input  logic        TABLE_START,
   input  logic [31:0] TABLE_DATA,
   input  logic        TABLE_WSTB,
   input  logic [31:0] REPEATS,
   input  logic [15:0] TABLE_LENGTH,
   input  logic        TABLE_LENGTH_WSTB,
   output logic [31:0] table_line_o,
   output logic [31:0] line_repeat_o,
   output logic [31:0] table_repeat_o,
   output logic [2:0]  state_o
);

   localparam int ADDR_W = $clog2(SEQ_LEN);

   state_t            state_q;
   logic              en_prev_q, active_q, loading_q;
   logic [2:0]        ld_idx_q;
   logic [OUT_W-1:0]  outs_q, ph1_q, ph2_q;
   logic [COND_W-1:0] cond_val_q, cond_mask_q;
   logic [31:0]       line_q, lrep_q, trep_q, presc_q, dur_q;
   logic [31:0]       rep_cnt_q, dur1_q, dur2_q;

   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;
   logic [13:0]       line_count;
   logic              en_rise, en_fall, trig_hit, phase_done, running;
   logic              more_lrep, more_line, more_table, finish, stop_all;
   logic [31:0]       presc_reload, presc_next, dur_next;

   // Position inputs are reserved; low length bits are ignored.
   logic unused_inputs;
   assign unused_inputs = ^{posa_i, posb_i, posc_i, TABLE_LENGTH[1:0]};

   seq_table #(.SEQ_LEN(SEQ_LEN)) u_table (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .table_start_i       (TABLE_START),
      .table_data_i        (TABLE_DATA),
      .table_wstb_i        (TABLE_WSTB),
      .table_lines_i       (TABLE_LENGTH[15:2]),
      .table_length_wstb_i (TABLE_LENGTH_WSTB),
      .rd_addr_i           (rd_addr),
      .rd_data_o           (rd_data),
      .line_count_o        (line_count)
   );

   // Edge detects, trigger compare, tick counters and end-of-line decisions.
   always_comb begin
      rd_addr      = {line_q[ADDR_W-3:0] - (ADDR_W-2)'(1), ld_idx_q[1:0]};
      en_rise      = enable_i && !en_prev_q;
      en_fall      = !enable_i && en_prev_q;
      trig_hit     = ((({bitc_i, bitb_i, bita_i} ^ cond_val_q) & cond_mask_q) == '0);
      presc_reload = tc_load(PRESCALE);
      phase_done   = (presc_q == 32'd0) && (dur_q == 32'd0);
      presc_next   = (presc_q == 32'd0) ? presc_reload : presc_q - 32'd1;
      dur_next     = (presc_q == 32'd0) ? dur_q - 32'd1 : dur_q;
      more_lrep    = (rep_cnt_q == 32'd0) || (lrep_q < rep_cnt_q);
      more_line    = line_q < 32'(line_count);
      more_table   = (REPEATS == 32'd0) || (trep_q < REPEATS);
      running      = (state_q == ST_WAIT_TRIGGER) || (state_q == ST_PHASE1) ||
                     (state_q == ST_PHASE2);
      finish       = (state_q == ST_PHASE2) && phase_done && !more_lrep &&
                     !more_line && !more_table;
      stop_all     = TABLE_START || TABLE_LENGTH_WSTB || (running && (en_fall || finish));
   end

   // Sequencer FSM with line prefetch and registered outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_UNREADY;
         en_prev_q   <= 1'b0;
         active_q    <= 1'b0;
         loading_q   <= 1'b0;
         ld_idx_q    <= '0;
         outs_q      <= '0;
         ph1_q       <= '0;
         ph2_q       <= '0;
         cond_val_q  <= '0;
         cond_mask_q <= '0;
         line_q      <= '0;
         lrep_q      <= '0;
         trep_q      <= '0;
         presc_q     <= '0;
         dur_q       <= '0;
         rep_cnt_q   <= '0;
         dur1_q      <= '0;
         dur2_q      <= '0;
      end else begin
         en_prev_q <= enable_i;
         if (loading_q) begin
            ld_idx_q <= ld_idx_q + 3'd1;
            case (ld_idx_q)
               3'd1: rep_cnt_q <= rd_data;
               3'd2: begin
                  cond_val_q  <= rd_data[W1_VAL_LSB  +: COND_W];
                  cond_mask_q <= rd_data[W1_MASK_LSB +: COND_W];
                  ph1_q       <= rd_data[W1_PH1_LSB  +: OUT_W];
                  ph2_q       <= rd_data[W1_PH2_LSB  +: OUT_W];
               end
               3'd3: dur1_q <= rd_data;
               3'd4: begin
                  dur2_q    <= rd_data;
                  loading_q <= 1'b0;
               end
               default: ;
            endcase
         end
         if (stop_all) begin
            if (TABLE_START)
               state_q <= ST_UNREADY;
            else if (TABLE_LENGTH_WSTB)
               state_q <= (TABLE_LENGTH[15:2] != '0) ? ST_WAIT_ENABLE : ST_UNREADY;
            else
               state_q <= ST_WAIT_ENABLE;
            active_q  <= 1'b0;
            loading_q <= 1'b0;
            outs_q    <= '0;
            line_q    <= '0;
            lrep_q    <= '0;
            trep_q    <= '0;
         end else begin
            case (state_q)
               ST_WAIT_ENABLE: if (en_rise) begin
                  state_q   <= ST_WAIT_TRIGGER;
                  active_q  <= 1'b1;
                  line_q    <= 32'd1;
                  lrep_q    <= 32'd1;
                  trep_q    <= 32'd1;
                  loading_q <= 1'b1;
                  ld_idx_q  <= '0;
               end
               ST_WAIT_TRIGGER: if (!loading_q && trig_hit) begin
                  state_q <= ST_PHASE1;
                  outs_q  <= ph1_q;
                  presc_q <= presc_reload;
                  dur_q   <= tc_load(dur1_q);
               end
               ST_PHASE1: if (phase_done) begin
                  state_q <= ST_PHASE2;
                  outs_q  <= ph2_q;
                  presc_q <= presc_reload;
                  dur_q   <= tc_load(dur2_q);
               end else begin
                  presc_q <= presc_next;
                  dur_q   <= dur_next;
               end
               ST_PHASE2: if (phase_done) begin
                  state_q <= ST_WAIT_TRIGGER;
                  if (more_lrep) begin
                     lrep_q <= lrep_q + 32'd1;
                  end else begin
                     line_q    <= more_line ? line_q + 32'd1 : 32'd1;
                     lrep_q    <= 32'd1;
                     trep_q    <= more_line ? trep_q : trep_q + 32'd1;
                     loading_q <= 1'b1;
                     ld_idx_q  <= '0;
                  end
               end else begin
                  presc_q <= presc_next;
                  dur_q   <= dur_next;
               end
               default: ;
            endcase
         end
      end
   end

   assign {outf_o, oute_o, outd_o, outc_o, outb_o, outa_o} = outs_q;
   assign active_o       = active_q;
   assign table_line_o   = line_q;
   assign line_repeat_o  = lrep_q;
   assign table_repeat_o = trep_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_sequencer.sv
module tb_sequencer;

   logic        clk_i = 1'b0;
   logic        reset_i, enable_i, bita_i, bitb_i, bitc_i;
   logic [31:0] posa_i, posb_i, posc_i;
   logic        outa_o, outb_o, outc_o, outd_o, oute_o, outf_o, active_o;
   logic [31:0] PRESCALE, TABLE_DATA, REPEATS;
   logic        TABLE_START, TABLE_WSTB, TABLE_LENGTH_WSTB;
   logic [15:0] TABLE_LENGTH;
   logic [31:0] table_line_o, line_repeat_o, table_repeat_o;
   logic [2:0]  state_o;

   int checks = 0;
   int failures = 0;

   sequencer dut (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .bita_i(bita_i), .bitb_i(bitb_i), .bitc_i(bitc_i),
      .posa_i(posa_i), .posb_i(posb_i), .posc_i(posc_i),
      .outa_o(outa_o), .outb_o(outb_o), .outc_o(outc_o),
      .outd_o(outd_o), .oute_o(oute_o), .outf_o(outf_o),
      .active_o(active_o), .PRESCALE(PRESCALE), .TABLE_START(TABLE_START),
      .TABLE_DATA(TABLE_DATA), .TABLE_WSTB(TABLE_WSTB), .REPEATS(REPEATS),
      .TABLE_LENGTH(TABLE_LENGTH), .TABLE_LENGTH_WSTB(TABLE_LENGTH_WSTB),
      .table_line_o(table_line_o), .line_repeat_o(line_repeat_o),
      .table_repeat_o(table_repeat_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] w1;
      logic [2:0]  bits;
      logic [2:0]  exp_state;
      logic [5:0]  exp_outs;
   } trig_vec_t;

   trig_vec_t vecs[7];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {outf_o, oute_o, outd_o, outc_o, outb_o, outa_o};
   endfunction

   task automatic wr_word(input logic [31:0] w);
      TABLE_DATA = w;
      TABLE_WSTB = 1'b1;
      tick();
      TABLE_WSTB = 1'b0;
   endtask

   task automatic tbl_start();
      TABLE_START = 1'b1;
      tick();
      TABLE_START = 1'b0;
   endtask

   task automatic commit(input logic [15:0] len);
      TABLE_LENGTH = len;
      TABLE_LENGTH_WSTB = 1'b1;
      tick();
      TABLE_LENGTH_WSTB = 1'b0;
   endtask

   task automatic load_line(input logic [31:0] w0, w1, w2, w3);
      wr_word(w0);
      wr_word(w1);
      wr_word(w2);
      wr_word(w3);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n = 0;
      while (state_o !== s && n < budget) begin
         tick();
         n++;
      end
      check(name, {29'd0, state_o}, {29'd0, s});
   endtask

   task automatic count_state(input logic [2:0] s, output int n);
      n = 0;
      while (state_o === s && n < 5000) begin
         n++;
         tick();
      end
   endtask

   task automatic restart();
      enable_i = 1'b0;
      tick();
      enable_i = 1'b1;
      tick();
   endtask

   initial begin
      int n, k, bad, guard;
      logic [2:0] prev;
      logic [23:0] exp_tuple[6];

      vecs[0] = '{32'h0002_0111, 3'b000, 3'd2, 6'h00};
      vecs[1] = '{32'h0002_0111, 3'b001, 3'd3, 6'h01};
      vecs[2] = '{32'h0000_3F75, 3'b101, 3'd3, 6'h3F};
      vecs[3] = '{32'h0000_3F75, 3'b111, 3'd2, 6'h00};
      vecs[4] = '{32'h0000_0A00, 3'b000, 3'd3, 6'h0A};
      vecs[5] = '{32'h0000_1520, 3'b101, 3'd3, 6'h15};
      vecs[6] = '{32'h0000_1520, 3'b010, 3'd2, 6'h00};
      exp_tuple = '{24'h010101, 24'h010201, 24'h020101, 24'h010102, 24'h010202, 24'h020102};

      reset_i = 1'b1; enable_i = 1'b0;
      bita_i = 1'b0; bitb_i = 1'b0; bitc_i = 1'b0;
      posa_i = 32'h1234; posb_i = 32'h5678; posc_i = 32'h9abc;
      PRESCALE = 32'd1; TABLE_DATA = '0; REPEATS = 32'd1; TABLE_LENGTH = '0;
      TABLE_START = 1'b0; TABLE_WSTB = 1'b0; TABLE_LENGTH_WSTB = 1'b0;
      repeat (3) tick();
      check("reset_state", {29'd0, state_o}, 32'd0);
      check("reset_outs", {26'd0, outs()}, 32'd0);
      check("reset_active", {31'd0, active_o}, 32'd0);
      check("reset_line", table_line_o, 32'd0);
      reset_i = 1'b0;
      tick();

      // Basic single line, PRESCALE=1
      tbl_start();
      load_line(32'd1, 32'h0000_0100, 32'd5, 32'd3);
      commit(16'd4);
      check("commit_state", {29'd0, state_o}, 32'd1);
      enable_i = 1'b1;
      tick();
      check("start_state", {29'd0, state_o}, 32'd2);
      check("start_active", {31'd0, active_o}, 32'd1);
      check("start_counters", {table_line_o[7:0], line_repeat_o[7:0], table_repeat_o[7:0]}, 32'h010101);
      wait_state(3'd3, 30, "t1_reach_ph1");
      check("t1_outa_ph1", {31'd0, outa_o}, 32'd1);
      count_state(3'd3, n);
      check("t1_ph1_len", n, 32'd5);
      check("t1_outa_ph2", {31'd0, outa_o}, 32'd0);
      count_state(3'd4, n);
      check("t1_ph2_len", n, 32'd3);
      check("t1_end_state", {29'd0, state_o}, 32'd1);
      check("t1_end_active", {31'd0, active_o}, 32'd0);
      check("t1_end_line", table_line_o, 32'd0);

      // Same table, PRESCALE=10
      PRESCALE = 32'd10;
      restart();
      wait_state(3'd3, 30, "t2_reach_ph1");
      bad = 0;
      n = 0;
      while (state_o === 3'd3 && n < 5000) begin
         if (table_line_o !== 32'd1 || line_repeat_o !== 32'd1 ||
             table_repeat_o !== 32'd1 || outa_o !== 1'b1) bad++;
         n++;
         tick();
      end
      check("t2_ph1_len", n, 32'd50);
      check("t2_counters_held", bad, 32'd0);
      count_state(3'd4, n);
      check("t2_ph2_len", n, 32'd30);

      // Zero durations with PRESCALE=0 behave as one tick of one clock
      PRESCALE = 32'd0;
      tbl_start();
      load_line(32'd1, 32'h0000_0100, 32'd0, 32'd0);
      commit(16'd4);
      restart();
      wait_state(3'd3, 30, "t0_reach_ph1");
      count_state(3'd3, n);
      check("t0_ph1_len", n, 32'd1);
      count_state(3'd4, n);
      check("t0_ph2_len", n, 32'd1);
      PRESCALE = 32'd1;

      // Trigger condition vectors
      for (int i = 0; i < 7; i++) begin
         enable_i = 1'b0;
         tbl_start();
         load_line(32'd1, vecs[i].w1, 32'd100, 32'd100);
         commit(16'd4);
         {bitc_i, bitb_i, bita_i} = vecs[i].bits;
         enable_i = 1'b1;
         repeat (10) tick();
         check($sformatf("trig_state_%0d", i), {29'd0, state_o}, {29'd0, vecs[i].exp_state});
         check($sformatf("trig_outs_%0d", i), {26'd0, outs()}, {26'd0, vecs[i].exp_outs});
      end

      // Trigger latency: raise bita while waiting, outputs follow one clock later
      enable_i = 1'b0;
      {bitc_i, bitb_i, bita_i} = 3'b000;
      tbl_start();
      load_line(32'd1, 32'h0002_0111, 32'd2, 32'd4);
      commit(16'd4);
      enable_i = 1'b1;
      repeat (10) tick();
      check("lat_hold_state", {29'd0, state_o}, 32'd2);
      bita_i = 1'b1;
      tick();
      check("lat_state", {29'd0, state_o}, 32'd3);
      check("lat_outs", {26'd0, outs()}, 32'h01);
      tick();
      tick();
      check("lat_ph2_outs", {26'd0, outs()}, 32'h02);
      bita_i = 1'b0;

      // Two lines with repeats, whole table twice
      enable_i = 1'b0;
      tbl_start();
      load_line(32'd2, 32'h0002_0100, 32'd1, 32'd1);
      load_line(32'd1, 32'h0002_0100, 32'd1, 32'd1);
      commit(16'd8);
      REPEATS = 32'd2;
      enable_i = 1'b1;
      tick();
      k = 0;
      guard = 0;
      prev = state_o;
      while (state_o !== 3'd1 && guard < 500) begin
         tick();
         if (state_o === 3'd3 && prev !== 3'd3) begin
            if (k < 6)
               check($sformatf("seq_tuple_%0d", k),
                     {8'd0, table_line_o[7:0], line_repeat_o[7:0], table_repeat_o[7:0]},
                     {8'd0, exp_tuple[k]});
            k++;
         end
         prev = state_o;
         guard++;
      end
      check("seq_count", k, 32'd6);
      check("seq_end_state", {29'd0, state_o}, 32'd1);
      REPEATS = 32'd1;

      // Falling enable in PHASE1
      tbl_start();
      load_line(32'd1, 32'h0000_0A00, 32'd100, 32'd100);
      commit(16'd4);
      restart();
      wait_state(3'd3, 30, "fall_reach_ph1");
      enable_i = 1'b0;
      tick();
      check("fall_state", {29'd0, state_o}, 32'd1);
      check("fall_outs", {26'd0, outs()}, 32'd0);
      check("fall_active", {31'd0, active_o}, 32'd0);
      check("fall_line", table_line_o, 32'd0);

      // TABLE_START mid-run and enable lockout
      enable_i = 1'b1;
      tick();
      wait_state(3'd3, 30, "ts_reach_ph1");
      tbl_start();
      check("ts_state", {29'd0, state_o}, 32'd0);
      check("ts_outs", {26'd0, outs()}, 32'd0);
      check("ts_active", {31'd0, active_o}, 32'd0);
      restart();
      repeat (8) tick();
      check("ts_ignore_enable", {29'd0, state_o}, 32'd0);
      commit(16'd3);
      check("ts_zero_len", {29'd0, state_o}, 32'd0);
      load_line(32'd1, 32'h0000_0A00, 32'd100, 32'd100);
      commit(16'd4);
      repeat (5) tick();
      check("ts_enable_high_commit", {29'd0, state_o}, 32'd1);
      restart();
      check("ts_restart", {29'd0, state_o}, 32'd2);
      wait_state(3'd3, 30, "rst_reach_ph1");

      // Asynchronous reset mid-run
      #2;
      reset_i = 1'b1;
      #1;
      check("arst_state", {29'd0, state_o}, 32'd0);
      check("arst_outs", {26'd0, outs()}, 32'd0);
      check("arst_active", {31'd0, active_o}, 32'd0);
      tick();
      reset_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
